// File: rtl/ddr2_request_arbiter_pkg.sv
// Shared definitions for the DDR2 request arbiter: MIG address-FIFO command codes,
// read-tag values that identify the owner of a returning read burst, FSM state encoding,
// round-robin pointer values and the per-cycle grant selection.
package ddr2_request_arbiter_pkg;

  localparam logic [2:0] AF_CMD_WRITE = 3'b000;
  localparam logic [2:0] AF_CMD_READ  = 3'b001;

  localparam logic TAG_PX  = 1'b0;
  localparam logic TAG_CPU = 1'b1;

  // Round-robin pointer: which of CPU/GFX wins when both are eligible.
  localparam logic RR_CPU = 1'b0;
  localparam logic RR_GFX = 1'b1;

  typedef enum logic {
    StIdle,
    StWr1
  } arb_state_e;

  typedef enum logic [1:0] {
    SelNone,
    SelPx,
    SelCpu,
    SelGfx
  } arb_sel_e;

endpackage

// File: rtl/ddr2_request_arbiter_read_tag_fifo.sv
// Read-tag FIFO: 1-bit wide, Depth-deep synchronous FIFO holding the owner tag of each
// outstanding read, oldest at the head.
// Ports: clk_i/rst_ni (synchronous, active low), push_i/din_i write side, pop_i read side,
// dout_o head entry, full_o/empty_o status, count_o occupancy (0..Depth).
// Push while full and pop while empty are ignored.
module ddr2_request_arbiter_read_tag_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       din_i,
  input  logic                       pop_i,
  output logic                       dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Depth-1:0] mem_q, mem_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ddr2_request_arbiter.sv
// DDR2 request arbiter: shares the MIG address/write-data/read-data FIFOs among the pixel
// feeder (reads), CPU cache (reads/writes) and graphics engine (writes).
// Ports: cpu_clk_g/rst_n (synchronous, active low); af_* address FIFO push side;
// wdf_* write-data FIFO push side; rdf_* read-data FIFO pop side (rdf_rd_en tied high);
// rd_data broadcast read beat; px_*/cpu_*/gfx_* requester handshakes (level request,
// single-cycle *_gnt) and per-requester read-beat valids.
// Write bursts are two 128-bit beats; the upper half is latched at grant and pushed from WR1.
// Each read returns two rdf beats, routed by the tag pushed when the read was issued.
module ddr2_request_arbiter
  import ddr2_request_arbiter_pkg::*;
#(
  parameter int unsigned TAG_DEPTH = 16,
  parameter bit          RR_INIT   = 1'b0
) (
  input  logic         cpu_clk_g,
  input  logic         rst_n,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  input  logic         wdf_full,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  input  logic         rdf_valid,
  input  logic [127:0] rdf_dout,
  output logic         rdf_rd_en,
  output logic [127:0] rd_data,
  input  logic         px_req,
  input  logic         px_urgent,
  input  logic [30:0]  px_addr,
  output logic         px_gnt,
  output logic         px_rd_valid,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [30:0]  cpu_addr,
  input  logic [255:0] cpu_wdata,
  input  logic [31:0]  cpu_wmask,
  output logic         cpu_gnt,
  output logic         cpu_rd_valid,
  input  logic         gfx_req,
  input  logic [30:0]  gfx_addr,
  input  logic [255:0] gfx_wdata,
  input  logic [31:0]  gfx_wmask,
  output logic         gfx_gnt
);

  localparam int unsigned TagCntW = $clog2(TAG_DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  logic             beat_q, beat_d;
  logic [127:0]     hi_data_q, hi_data_d;
  logic [15:0]      hi_mask_q, hi_mask_d;

  arb_sel_e         sel;
  logic             rd_ok, wr_ok, px_ok, cpu_ok, gfx_ok;
  logic             tag_push, tag_push_val, tag_pop;
  logic             tag_head, tag_full, tag_empty;
  logic [TagCntW-1:0] tag_count;
  logic             beat_live;

  ddr2_request_arbiter_read_tag_fifo #(
    .Depth (TAG_DEPTH)
  ) u_read_tag_fifo (
    .clk_i   (cpu_clk_g),
    .rst_ni  (rst_n),
    .push_i  (tag_push),
    .din_i   (tag_push_val),
    .pop_i   (tag_pop),
    .dout_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_count)
  );

  // Eligibility: a requester that cannot proceed is skipped so it never blocks others
  // (e.g. writes continue while the tag queue is full).
  always_comb begin
    rd_ok  = !af_full && !tag_full;
    wr_ok  = !af_full && !wdf_full;
    px_ok  = px_req && rd_ok;
    cpu_ok = cpu_req && (cpu_we ? wr_ok : rd_ok);
    gfx_ok = gfx_req && wr_ok;
    sel    = SelNone;
    if (state_q == StIdle) begin
      if (px_ok && px_urgent) begin
        sel = SelPx;
      end else if (cpu_ok && (!gfx_ok || rr_q == RR_CPU)) begin
        sel = SelCpu;
      end else if (gfx_ok) begin
        sel = SelGfx;
      end else if (px_ok) begin
        sel = SelPx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    hi_data_d    = hi_data_q;
    hi_mask_d    = hi_mask_q;
    af_wr_en     = 1'b0;
    af_cmd_din   = AF_CMD_WRITE;
    af_addr_din  = '0;
    wdf_wr_en    = 1'b0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    px_gnt       = 1'b0;
    cpu_gnt      = 1'b0;
    gfx_gnt      = 1'b0;
    tag_push     = 1'b0;
    tag_push_val = TAG_PX;

    unique case (state_q)
      StIdle: begin
        unique case (sel)
          SelPx: begin
            px_gnt       = 1'b1;
            af_wr_en     = 1'b1;
            af_cmd_din   = AF_CMD_READ;
            af_addr_din  = px_addr;
            tag_push     = 1'b1;
            tag_push_val = TAG_PX;
          end
          SelCpu: begin
            cpu_gnt     = 1'b1;
            rr_d        = RR_GFX;
            af_wr_en    = 1'b1;
            af_addr_din = cpu_addr;
            if (cpu_we) begin
              af_cmd_din   = AF_CMD_WRITE;
              wdf_wr_en    = 1'b1;
              wdf_din      = cpu_wdata[127:0];
              wdf_mask_din = cpu_wmask[15:0];
              hi_data_d    = cpu_wdata[255:128];
              hi_mask_d    = cpu_wmask[31:16];
              state_d      = StWr1;
            end else begin
              af_cmd_din   = AF_CMD_READ;
              tag_push     = 1'b1;
              tag_push_val = TAG_CPU;
            end
          end
          SelGfx: begin
            gfx_gnt      = 1'b1;
            rr_d         = RR_CPU;
            af_wr_en     = 1'b1;
            af_cmd_din   = AF_CMD_WRITE;
            af_addr_din  = gfx_addr;
            wdf_wr_en    = 1'b1;
            wdf_din      = gfx_wdata[127:0];
            wdf_mask_din = gfx_wmask[15:0];
            hi_data_d    = gfx_wdata[255:128];
            hi_mask_d    = gfx_wmask[31:16];
            state_d      = StWr1;
          end
          default: ;
        endcase
      end
      StWr1: begin
        // Second beat only; no grants here so reads cannot split a write burst.
        wdf_din      = hi_data_q;
        wdf_mask_din = hi_mask_q;
        if (!wdf_full) begin
          wdf_wr_en = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Return path: head tag steers each beat; the tag retires on the second beat.
  always_comb begin
    beat_live    = rdf_valid && !tag_empty;
    px_rd_valid  = beat_live && (tag_head == TAG_PX);
    cpu_rd_valid = beat_live && (tag_head == TAG_CPU);
    tag_pop      = beat_live && beat_q;
    beat_d       = beat_q ^ beat_live;
  end

  assign rdf_rd_en = 1'b1;
  assign rd_data   = rdf_dout;

  always_ff @(posedge cpu_clk_g) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_q      <= RR_INIT;
      beat_q    <= 1'b0;
      hi_data_q <= '0;
      hi_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      hi_data_q <= hi_data_d;
      hi_mask_q <= hi_mask_d;
    end
  end

  // A read beat with no outstanding tag means the MIG returned data nobody asked for.
  rdf_without_tag: assert property (@(posedge cpu_clk_g) disable iff (!rst_n)
    rdf_valid |-> !tag_empty);

  tag_count_in_range: assert property (@(posedge cpu_clk_g) disable iff (!rst_n)
    tag_count <= TagCntW'(TAG_DEPTH));

endmodule

// File: tb/tb_ddr2_request_arbiter.sv
// Directed bench for ddr2_request_arbiter: inputs change 1 time unit after the rising edge,
// outputs are checked 2 units later, well before the next edge.
module tb_ddr2_request_arbiter;

  logic         cpu_clk_g;
  logic         rst_n;
  logic         af_full;
  logic         af_wr_en;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         wdf_full;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         rdf_valid;
  logic [127:0] rdf_dout;
  logic         rdf_rd_en;
  logic [127:0] rd_data;
  logic         px_req, px_urgent, px_gnt, px_rd_valid;
  logic [30:0]  px_addr;
  logic         cpu_req, cpu_we, cpu_gnt, cpu_rd_valid;
  logic [30:0]  cpu_addr;
  logic [255:0] cpu_wdata;
  logic [31:0]  cpu_wmask;
  logic         gfx_req, gfx_gnt;
  logic [30:0]  gfx_addr;
  logic [255:0] gfx_wdata;
  logic [31:0]  gfx_wmask;

  int n_checks;
  int n_fail;

  ddr2_request_arbiter #(
    .TAG_DEPTH (16),
    .RR_INIT   (1'b0)
  ) dut (
    .cpu_clk_g    (cpu_clk_g),
    .rst_n        (rst_n),
    .af_full      (af_full),
    .af_wr_en     (af_wr_en),
    .af_cmd_din   (af_cmd_din),
    .af_addr_din  (af_addr_din),
    .wdf_full     (wdf_full),
    .wdf_wr_en    (wdf_wr_en),
    .wdf_din      (wdf_din),
    .wdf_mask_din (wdf_mask_din),
    .rdf_valid    (rdf_valid),
    .rdf_dout     (rdf_dout),
    .rdf_rd_en    (rdf_rd_en),
    .rd_data      (rd_data),
    .px_req       (px_req),
    .px_urgent    (px_urgent),
    .px_addr      (px_addr),
    .px_gnt       (px_gnt),
    .px_rd_valid  (px_rd_valid),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wmask    (cpu_wmask),
    .cpu_gnt      (cpu_gnt),
    .cpu_rd_valid (cpu_rd_valid),
    .gfx_req      (gfx_req),
    .gfx_addr     (gfx_addr),
    .gfx_wdata    (gfx_wdata),
    .gfx_wmask    (gfx_wmask),
    .gfx_gnt      (gfx_gnt)
  );

  initial cpu_clk_g = 1'b0;
  always #5 cpu_clk_g = ~cpu_clk_g;

  localparam logic [127:0] BeatA = {4{32'hAAAA_0001}};
  localparam logic [127:0] BeatB = {4{32'hBBBB_0002}};
  localparam logic [127:0] BeatC = {4{32'hCCCC_0003}};
  localparam logic [127:0] BeatD = {4{32'hDDDD_0004}};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk_g);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    af_full   = 1'b0;
    wdf_full  = 1'b0;
    rdf_valid = 1'b0;
    rdf_dout  = '0;
    px_req    = 1'b0;
    px_urgent = 1'b0;
    px_addr   = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = {BeatB, BeatA};
    cpu_wmask = 32'h1234_5678;
    gfx_req   = 1'b0;
    gfx_addr  = '0;
    gfx_wdata = {BeatD, BeatC};
    gfx_wmask = 32'h9ABC_DEF0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic exp_px_pat [6];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    step();
    step();
    settle();
    // Reset state
    check_eq("rst_af_wr_en", 128'(af_wr_en), 128'd0);
    check_eq("rst_wdf_wr_en", 128'(wdf_wr_en), 128'd0);
    check_eq("rst_gnts", 128'({px_gnt, cpu_gnt, gfx_gnt}), 128'd0);
    check_eq("rst_rd_valid", 128'({px_rd_valid, cpu_rd_valid}), 128'd0);
    check_eq("rdf_rd_en", 128'(rdf_rd_en), 128'd1);
    rst_n = 1'b1;
    step();

    // 1+2: urgent pixel read beats CPU write; then CPU write bursts A then B.
    px_req = 1'b1; px_urgent = 1'b1; px_addr = 31'h40;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 31'h1000;
    settle();
    check_eq("t1_px_gnt", 128'(px_gnt), 128'd1);
    check_eq("t1_cpu_gnt_wait", 128'(cpu_gnt), 128'd0);
    check_eq("t1_af_cmd_rd", 128'(af_cmd_din), 128'h1);
    check_eq("t1_af_addr_px", 128'(af_addr_din), 128'h40);
    step();
    px_req = 1'b0; px_urgent = 1'b0;
    settle();
    check_eq("t2_cpu_gnt", 128'(cpu_gnt), 128'd1);
    check_eq("t2_af_wr_en", 128'(af_wr_en), 128'd1);
    check_eq("t2_af_cmd_wr", 128'(af_cmd_din), 128'h0);
    check_eq("t2_af_addr", 128'(af_addr_din), 128'h1000);
    check_eq("t2_wdf_en_beat0", 128'(wdf_wr_en), 128'd1);
    check_eq("t2_wdf_beat0", wdf_din, BeatA);
    check_eq("t2_mask_beat0", 128'(wdf_mask_din), 128'h5678);
    step();
    cpu_req = 1'b0;
    settle();
    check_eq("t2_cpu_gnt_once", 128'(cpu_gnt), 128'd0);
    check_eq("t2_af_idle_wr1", 128'(af_wr_en), 128'd0);
    check_eq("t2_wdf_en_beat1", 128'(wdf_wr_en), 128'd1);
    check_eq("t2_wdf_beat1", wdf_din, BeatB);
    check_eq("t2_mask_beat1", 128'(wdf_mask_din), 128'h1234);
    step();
    settle();
    check_eq("t2_wdf_done", 128'(wdf_wr_en), 128'd0);
    // Retire the pixel read from test 1.
    rdf_valid = 1'b1; rdf_dout = BeatC;
    settle();
    check_eq("t1_ret0_px", 128'({px_rd_valid, cpu_rd_valid}), 128'b10);
    step();
    settle();
    check_eq("t1_ret1_px", 128'({px_rd_valid, cpu_rd_valid}), 128'b10);
    step();
    rdf_valid = 1'b0;

    // 3: CPU and GFX writes held; grants alternate starting with CPU (RR_INIT=0).
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; gfx_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq($sformatf("t3_cpu_gnt%0d", i), 128'(cpu_gnt), 128'((i % 2) == 0));
      check_eq($sformatf("t3_gfx_gnt%0d", i), 128'(gfx_gnt), 128'((i % 2) == 1));
      check_eq($sformatf("t3_beat0_%0d", i), wdf_din, ((i % 2) == 0) ? BeatA : BeatC);
      step();
      settle();
      check_eq($sformatf("t3_wr1_nognt%0d", i), 128'({cpu_gnt, gfx_gnt}), 128'd0);
      check_eq($sformatf("t3_beat1_%0d", i), wdf_din, ((i % 2) == 0) ? BeatB : BeatD);
      step();
    end
    // Reset while in WR1 discards the second beat.
    step();
    do_reset();
    settle();
    check_eq("t3_rst_mid_wdf", 128'(wdf_wr_en), 128'd0);
    check_eq("t3_rst_mid_af", 128'(af_wr_en), 128'd0);

    // 4: reads PX, CPU, PX; six beats route px,px,cpu,cpu,px,px.
    px_req = 1'b1; px_addr = 31'h100;
    settle();
    check_eq("t4_px_gnt_a", 128'(px_gnt), 128'd1);
    step();
    px_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 31'h200;
    settle();
    check_eq("t4_cpu_gnt", 128'(cpu_gnt), 128'd1);
    check_eq("t4_cpu_cmd_rd", 128'(af_cmd_din), 128'h1);
    check_eq("t4_cpu_no_wdf", 128'(wdf_wr_en), 128'd0);
    step();
    cpu_req = 1'b0; px_req = 1'b1;
    settle();
    check_eq("t4_px_gnt_b", 128'(px_gnt), 128'd1);
    step();
    px_req = 1'b0;
    exp_px_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      rdf_valid = 1'b1;
      rdf_dout  = 128'(i + 32'h5500);
      settle();
      check_eq($sformatf("t4_px_rv%0d", i), 128'(px_rd_valid), 128'(exp_px_pat[i]));
      check_eq($sformatf("t4_cpu_rv%0d", i), 128'(cpu_rd_valid), 128'(!exp_px_pat[i]));
      check_eq($sformatf("t4_rd_data%0d", i), rd_data, 128'(i + 32'h5500));
      step();
    end
    rdf_valid = 1'b0;

    // 5: sixteen outstanding reads fill the tag queue; the 17th waits for a pop.
    do_reset();
    px_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      px_addr = 31'(i);
      settle();
      check_eq($sformatf("t5_px_gnt%0d", i), 128'(px_gnt), 128'd1);
      step();
    end
    settle();
    check_eq("t5_full_blocks", 128'(px_gnt), 128'd0);
    rdf_valid = 1'b1;
    settle();
    check_eq("t5_beat0_blocks", 128'(px_gnt), 128'd0);
    check_eq("t5_beat0_rv", 128'(px_rd_valid), 128'd1);
    step();
    settle();
    check_eq("t5_beat1_blocks", 128'(px_gnt), 128'd0);
    step();
    rdf_valid = 1'b0;
    settle();
    check_eq("t5_after_pop_gnt", 128'(px_gnt), 128'd1);
    step();
    px_req = 1'b0;

    // 6: wdf_full during WR1 holds the second beat; no read sneaks in meanwhile.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 31'h2000;
    settle();
    check_eq("t6_cpu_gnt", 128'(cpu_gnt), 128'd1);
    step();
    cpu_req = 1'b0; wdf_full = 1'b1; px_req = 1'b1; px_urgent = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq($sformatf("t6_stall_wdf%0d", i), 128'(wdf_wr_en), 128'd0);
      check_eq($sformatf("t6_stall_px%0d", i), 128'(px_gnt), 128'd0);
      step();
    end
    wdf_full = 1'b0;
    settle();
    check_eq("t6_release_wdf", 128'(wdf_wr_en), 128'd1);
    check_eq("t6_release_beat", wdf_din, BeatB);
    check_eq("t6_release_px", 128'(px_gnt), 128'd0);
    step();
    settle();
    check_eq("t6_px_after", 128'(px_gnt), 128'd1);
    check_eq("t6_wdf_after", 128'(wdf_wr_en), 128'd0);
    step();
    af_full = 1'b1;
    settle();
    check_eq("t6_af_full_blocks", 128'(px_gnt), 128'd0);
    check_eq("t6_af_full_no_push", 128'(af_wr_en), 128'd0);
    step();
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
